// File: rtl/ccl_raster_labeler.sv
// ccl_raster_labeler: two-pass raster connected-component labeler, ROM bitmap in, consecutive labels out to SRAM.
module ccl_raster_labeler #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int ROM_DW  = 8,
  parameter int ROM_AW  = 7,
  parameter int SRAM_AW = 10,
  parameter int LBL_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 conn8,
  output logic [ROM_AW-1:0]    rom_a,
  input  logic [ROM_DW-1:0]    rom_q,
  output logic [SRAM_AW-1:0]   sram_a,
  output logic [LBL_W-1:0]     sram_d,
  output logic                 sram_wen,
  output logic                 finish,
  output logic                 ovf
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW = $clog2(IMG_W);
  localparam int DB = $clog2(ROM_DW);
  localparam int LDW = ROM_AW + 1;
  localparam logic [ROM_AW:0] LD_END = LDW'(NPIX / ROM_DW);
  localparam logic [SRAM_AW-1:0] P_LAST = SRAM_AW'(NPIX - 1);
  localparam logic [SRAM_AW-1:0] ROW = SRAM_AW'(IMG_W);
  localparam logic [SRAM_AW-1:0] ONE = SRAM_AW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, SCAN, RESOLVE, WRITE, DONE} state_t;
  state_t state, nxt;

  logic [ROM_AW:0] ld;
  logic [SRAM_AW-1:0] p;
  logic [LBL_W-1:0] cnt, k, fid, nl, lab, rw, rn, rnw, rne, mn, mx;
  logic [CW-1:0] col;
  logic c8, go, fg, has_w, has_n;
  logic [ROM_DW-1:0] bm [2**ROM_AW];
  logic [LBL_W-1:0] lbl [2**SRAM_AW];
  logic [LBL_W-1:0] eq [2**LBL_W];

  function automatic logic [LBL_W-1:0] min_nz(input logic [LBL_W-1:0] a, input logic [LBL_W-1:0] b);
    return a == '0 ? b : (b == '0 || a < b) ? a : b;
  endfunction

  function automatic logic [LBL_W-1:0] max2(input logic [LBL_W-1:0] a, input logic [LBL_W-1:0] b);
    return a > b ? a : b;
  endfunction

  assign go = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: nxt = go ? LOAD : state;
      LOAD:       nxt = ld == LD_END ? SCAN : LOAD;
      SCAN:       nxt = p == P_LAST ? RESOLVE : SCAN;
      RESOLVE:    nxt = (cnt == '0 || k == cnt) ? WRITE : RESOLVE;
      WRITE:      nxt = p == P_LAST ? DONE : WRITE;
      default:    nxt = IDLE;
    endcase
  end

  always_comb begin
    rom_a = ROM_AW'(ld == LD_END ? ld - 1'b1 : ld);
    sram_wen = state != WRITE;
    sram_a = (state == WRITE || state == DONE) ? p : '0;
    sram_d = state == WRITE ? eq[lbl[p]] : '0;
    finish = state == DONE;
  end

  // eq is kept flat (every entry points straight at its root), so one lookup per neighbour
  // finds its root and a merge can only ever involve two distinct roots.
  always_comb begin
    col = p[CW-1:0];
    has_w = col != '0;
    has_n = p >= ROW;
    rw = has_w ? eq[lbl[p - ONE]] : '0;
    rn = has_n ? eq[lbl[p - ROW]] : '0;
    rnw = (c8 && has_n && has_w) ? eq[lbl[p - ROW - ONE]] : '0;
    rne = (c8 && has_n && col != '1) ? eq[lbl[p - ROW + ONE]] : '0;
    mn = min_nz(min_nz(rw, rn), min_nz(rnw, rne));
    mx = max2(max2(rw, rn), max2(rnw, rne));
    nl = cnt + 1'b1;
    fg = bm[ROM_AW'(p >> DB)][~p[DB-1:0]];
    lab = !fg ? '0 : mx != '0 ? mn : cnt == '1 ? '0 : nl;
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && ld != '0) bm[ROM_AW'(ld - 1'b1)] <= rom_q;
    if (state == SCAN) lbl[p] <= lab;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ld <= '0;
      p <= '0;
      cnt <= '0;
      k <= '0;
      fid <= '0;
      ovf <= 1'b0;
      c8 <= 1'b0;
      for (int i = 0; i < 2**LBL_W; i++) eq[i] <= '0;
    end else if (go) begin
      ld <= '0;
      p <= '0;
      cnt <= '0;
      k <= LBL_W'(1);
      fid <= '0;
      ovf <= 1'b0;
      c8 <= conn8;
      for (int i = 0; i < 2**LBL_W; i++) eq[i] <= '0;
    end else begin
      if (state == LOAD && ld != LD_END) ld <= ld + 1'b1;
      if (state == SCAN) begin
        p <= p == P_LAST ? '0 : p + 1'b1;
        if (fg && mx == '0 && cnt == '1) ovf <= 1'b1;
        if (fg && mx == '0 && cnt != '1) begin
          cnt <= nl;
          eq[nl] <= nl;
        end
        if (fg && mx != mn)
          for (int i = 1; i < 2**LBL_W; i++)
            if (eq[i] == mx) eq[i] <= mn;
      end
      // in place: roots take the next id, others copy their (already resolved) root's id
      if (state == RESOLVE && cnt != '0) begin
        eq[k] <= eq[k] == k ? fid + 1'b1 : eq[eq[k]];
        fid <= eq[k] == k ? fid + 1'b1 : fid;
        k <= k + 1'b1;
      end
      if (state == WRITE && p != P_LAST) p <= p + 1'b1;
    end
endmodule

// File: tb/tb_ccl_raster_labeler.sv
// tb_ccl_raster_labeler: scoreboard bench for a 32x32 and a 64x16 labeler against a flood-fill model.
module tb_ccl_raster_labeler;
  logic clk = 0;
  logic reset = 1;
  logic [1:0] start = '0;
  logic [1:0] conn8 = '0;
  logic [1:0] sram_wen, finish, ovf;
  logic [1:0][6:0] rom_a;
  logic [1:0][7:0] rom_q, sram_d;
  logic [1:0][9:0] sram_a;
  logic [7:0] rom [128];
  bit img [1024];
  int exp_a[$];
  int exp_d[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_wr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    ccl_raster_labeler #(
      .IMG_W(g ? 64 : 32), .IMG_H(g ? 16 : 32), .ROM_DW(8),
      .ROM_AW(7), .SRAM_AW(10), .LBL_W(8)
    ) dut (
      .clk(clk), .reset(reset), .start(start[g]), .conn8(conn8[g]),
      .rom_a(rom_a[g]), .rom_q(rom_q[g]), .sram_a(sram_a[g]), .sram_d(sram_d[g]),
      .sram_wen(sram_wen[g]), .finish(finish[g]), .ovf(ovf[g])
    );
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rom_q[0] <= rom[rom_a[0]];
    rom_q[1] <= rom[rom_a[1]];
  end

  always @(negedge clk)
    for (int g = 0; g < 2; g++)
      if (!sram_wen[g]) begin
        if (exp_a.size() == 0) chk("extra_write", 1, 0);
        else begin
          chk("addr", int'(sram_a[g]), exp_a.pop_front());
          chk("data", int'(sram_d[g]), exp_d.pop_front());
        end
        if (sram_a[g] != 0) chk("no_gap", cyc - last_wr, 1);
        last_wr = cyc;
      end

  function automatic int wid(input int g);
    return g ? 64 : 32;
  endfunction

  task automatic clear_img();
    foreach (img[i]) img[i] = 0;
  endtask

  task automatic rand_img(input int pct);
    foreach (img[i]) img[i] = $urandom_range(99) < pct;
  endtask

  task automatic load_rom();
    for (int p = 0; p < 1024; p++) rom[p / 8][7 - p % 8] = img[p];
  endtask

  task automatic golden(input int g, input bit c8, output int nc);
    int lab[1024];
    bit vis[1024];
    int st[$];
    int w, h, q, r, c, rr, cc, n;
    w = wid(g);
    h = 1024 / w;
    nc = 0;
    foreach (lab[i]) begin lab[i] = 0; vis[i] = 0; end
    for (int p = 0; p < 1024; p++)
      if (img[p] && !vis[p]) begin
        nc++;
        vis[p] = 1;
        st.push_back(p);
        while (st.size() > 0) begin
          q = st.pop_back();
          lab[q] = nc > 255 ? 0 : nc;
          r = q / w;
          c = q % w;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              rr = r + dr;
              cc = c + dc;
              if ((dr != 0 || dc != 0) && (c8 || dr == 0 || dc == 0) &&
                  rr >= 0 && rr < h && cc >= 0 && cc < w) begin
                n = rr * w + cc;
                if (img[n] && !vis[n]) begin vis[n] = 1; st.push_back(n); end
              end
            end
        end
      end
    for (int p = 0; p < 1024; p++) begin exp_a.push_back(p); exp_d.push_back(lab[p]); end
  endtask

  task automatic pulse_start(input int g, input bit c8);
    @(posedge clk); #1;
    conn8[g] = c8;
    start[g] = 1;
    @(posedge clk); #1;
    start[g] = 0;
  endtask

  task automatic run(input int g, input bit c8);
    int nc, n;
    golden(g, c8, nc);
    load_rom();
    pulse_start(g, c8);
    n = 0;
    while (!finish[g] && n < 20000) begin @(negedge clk); n++; end
    chk("finish", int'(finish[g]), 1);
    chk("finish_latency", cyc - last_wr, 1);
    chk("wen_after", int'(sram_wen[g]), 1);
    chk("all_written", exp_a.size(), 0);
    chk("ovf", int'(ovf[g]), int'(nc > 255));
    exp_a.delete();
    exp_d.delete();
  endtask

  task automatic chk_reset_vals(input int g);
    chk("rst_rom_a", int'(rom_a[g]), 0);
    chk("rst_sram_a", int'(sram_a[g]), 0);
    chk("rst_sram_d", int'(sram_d[g]), 0);
    chk("rst_wen", int'(sram_wen[g]), 1);
    chk("rst_finish", int'(finish[g]), 0);
    chk("rst_ovf", int'(ovf[g]), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals(0);
    chk_reset_vals(1);
    reset = 0;
    clear_img();
    run(0, 1);
    img[0] = 1;
    img[33] = 1;
    run(0, 1);
    run(0, 0);
    clear_img();
    for (int r = 2; r <= 8; r++) begin img[r * 32 + 2] = 1; img[r * 32 + 6] = 1; end
    for (int c = 2; c <= 6; c++) img[8 * 32 + c] = 1;
    run(0, 0);
    run(0, 1);
    clear_img();
    for (int p = 0; p < 1024; p++) img[p] = ((p / 32 + p % 32) % 2) == 0;
    run(0, 0);
    rand_img(35);
    run(1, 1);
    run(1, 0);
    rand_img(50);
    load_rom();
    pulse_start(0, 1);
    repeat (300) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk_reset_vals(0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rand_img(40);
    run(0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
